// File: rtl/adder.sv
// WIDTH-bit add/subtract with a zero-latency combinational result and an optional registered copy.
// Define ADDER_SAT_EN to make the registered result saturate on signed overflow.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             en,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [WIDTH-1:0] res_q,
    output logic [3:0]       flags_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] op2_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] cap_res;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;
    logic             valid_d;

    // Subtraction reuses the adder: op1 + ~op2 + 1, so carry-out means "no borrow".
    always_comb begin
        op2_eff  = sub ? ~op2 : op2;
        sum      = {1'b0, op1} + {1'b0, op2_eff} + {{WIDTH{1'b0}}, sub};
        res      = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (op1[WIDTH-1] == op2_eff[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
        zero     = (res == '0);
        negative = res[WIDTH-1];
    end

    always_comb begin
        cap_res = res;
`ifdef ADDER_SAT_EN
        // Clamp toward the sign of op1; the overflow flag keeps the raw indication.
        if (overflow) begin
            cap_res = op1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = 1'b0;
        if (en) begin
            res_d   = cap_res;
            flags_d = {carry, overflow, (cap_res == '0), cap_res[WIDTH-1]};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            flags_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: stimulus pushes expected captures, a monitor pops them on valid_q.
// Reference model uses signed/unsigned 64-bit arithmetic; honours ADDER_SAT_EN when defined.
module tb_adder;

    logic        clk;
    logic        reset;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    logic        en;
    logic [31:0] res;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;
    logic [31:0] res_q;
    logic [3:0]  flags_q;
    logic        valid_q;

    bit clkRun;
    int checkCount;
    int passCount;

    typedef struct {
        logic [31:0] resVal;
        logic [3:0]  flagsVal;
    } capture_t;

    capture_t    expQueue[$];
    logic [31:0] lastRes;
    logic [3:0]  lastFlags;

    adder #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op1      (op1),
        .op2      (op2),
        .sub      (sub),
        .en       (en),
        .res      (res),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative),
        .res_q    (res_q),
        .flags_q  (flags_q),
        .valid_q  (valid_q)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clkRun) clk = ~clk;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (op1=0x%08h op2=0x%08h sub=%0b)",
                     name, actual, expected, op1, op2, sub);
        end
    endtask

    // Golden model from plain integer arithmetic on the mathematical values.
    task automatic refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [31:0] r, output logic [3:0] f,
                            output logic [31:0] rq, output logic [3:0] fq);
        longint ua, ub, sa, sb, exact, full;
        logic c, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            full = ua - ub + 64'sh1_0000_0000;
            c    = (ua >= ub);
            exact = sa - sb;
        end else begin
            full = ua + ub;
            c    = (full >= 64'sh1_0000_0000);
            exact = sa + sb;
        end
        r  = full[31:0];
        ov = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        f  = {c, ov, (r == 32'h0), r[31]};
        rq = r;
`ifdef ADDER_SAT_EN
        if (exact > 64'sd2147483647) rq = 32'h7FFF_FFFF;
        else if (exact < -64'sd2147483648) rq = 32'h8000_0000;
`endif
        fq = {c, ov, (rq == 32'h0), rq[31]};
    endtask

    task automatic checkComb(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] r, rq;
        logic [3:0]  f, fq;
        refModel(a, b, s, r, f, rq, fq);
        checkOutput("comb_res", {32'h0, res}, {32'h0, r});
        checkOutput("comb_flags", {60'h0, carry, overflow, zero, negative}, {60'h0, f});
    endtask

    // One clock cycle: drive at negedge, check the combinational path, predict the register stage.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic e, input logic r);
        logic [31:0] cr, rq;
        logic [3:0]  cf, fq;
        capture_t    item;
        @(negedge clk);
        op1   = a;
        op2   = b;
        sub   = s;
        en    = e;
        reset = r;
        #1;
        checkComb(a, b, s);
        refModel(a, b, s, cr, cf, rq, fq);
        if (r) begin
            lastRes   = 32'h0;
            lastFlags = 4'h0;
        end else if (e) begin
            item.resVal   = rq;
            item.flagsVal = fq;
            expQueue.push_back(item);
            lastRes   = rq;
            lastFlags = fq;
        end
        @(posedge clk);
        #1;
        if (r || !e) begin
            checkOutput("reg_res_hold", {32'h0, res_q}, {32'h0, lastRes});
            checkOutput("reg_flags_hold", {60'h0, flags_q}, {60'h0, lastFlags});
            checkOutput("reg_valid_low", {63'h0, valid_q}, 64'h0);
        end
    endtask

    // Monitor: every presented capture must match the oldest pending expectation.
    always @(negedge clk) begin
        capture_t item;
        if (valid_q === 1'b1) begin
            if (expQueue.size() == 0) begin
                checkOutput("sb_spurious_valid", 64'h1, 64'h0);
            end else begin
                item = expQueue.pop_front();
                checkOutput("sb_res_q", {32'h0, res_q}, {32'h0, item.resVal});
                checkOutput("sb_flags_q", {60'h0, flags_q}, {60'h0, item.flagsVal});
            end
        end
    end

    function automatic logic [31:0] pickOperand();
        logic [31:0] corner[6];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        corner[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] dirA[5];
        logic [31:0] dirB[5];
        logic        dirS[5];
        checkCount = 0;
        passCount  = 0;
        clkRun     = 1'b0;
        reset      = 1'b1;
        en         = 1'b0;
        lastRes    = 32'h0;
        lastFlags  = 4'h0;

        dirA[0] = 32'h0000_0001; dirB[0] = 32'h0000_0002; dirS[0] = 1'b0;
        dirA[1] = 32'hFFFF_FFFF; dirB[1] = 32'h0000_0001; dirS[1] = 1'b0;
        dirA[2] = 32'h7FFF_FFFF; dirB[2] = 32'h0000_0001; dirS[2] = 1'b0;
        dirA[3] = 32'h0000_0005; dirB[3] = 32'h0000_0007; dirS[3] = 1'b1;
        dirA[4] = 32'h0000_0007; dirB[4] = 32'h0000_0007; dirS[4] = 1'b1;

        // Combinational path with the clock stopped.
        for (int i = 0; i < 5; i++) begin
            op1 = dirA[i];
            op2 = dirB[i];
            sub = dirS[i];
            #10;
            checkComb(dirA[i], dirB[i], dirS[i]);
        end
        checkOutput("dir_ovf_res", {32'h0, res}, 64'h0);
        checkOutput("dir_sub_eq_carry", {63'h0, carry}, 64'h1);

        clkRun = 1'b1;
        applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checkOutput("sb_queue_drained", 64'(expQueue.size()), 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- 32-bit integer adder used in the datapath, e.g. PC increment and branch-target computation.
- Combinational result `res = op1 + op2` (modulo 2^WIDTH) is always available with zero latency.
- A registered copy of the result and its status flags is provided for pipelined consumers.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op1  input  WIDTH  first operand
- op2  input  WIDTH  second operand
- sub  input  1  0 = op1 + op2; 1 = op1 - op2, computed as op1 + ~op2 + 1
- en  input  1  capture enable for the registered stage
- res  output  WIDTH  combinational sum or difference, modulo 2^WIDTH
- carry  output  1  combinational carry-out of the WIDTH-bit adder (for sub, 1 = no borrow)
- overflow  output  1  combinational signed overflow
- zero  output  1  combinational, res == 0
- negative  output  1  combinational, res[WIDTH-1]
- res_q  output  WIDTH  registered res
- flags_q  output  4  registered {carry, overflow, zero, negative}, bit 3 = carry
- valid_q  output  1  high for the cycle after a capture

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Combinational path:
  - res, carry, overflow, zero and negative are pure functions of op1, op2 and sub.
  - They are unaffected by clk, reset and en.
  - They settle within the same evaluation, with no clock required.
- Arithmetic:
  - Form a WIDTH+1-bit sum = {0,op1} + {0,op2'} + sub, where op2' = sub ? ~op2 : op2.
  - res = sum[WIDTH-1:0]; carry = sum[WIDTH].
- Overflow:
  - overflow = (op1[MSB] == op2'[MSB]) && (res[MSB] != op1[MSB]).
  - For WIDTH=32: 0x7FFFFFFF + 1 gives res = 0x80000000, overflow = 1, carry = 0.
  - 0xFFFFFFFF + 1 gives res = 0x00000000, carry = 1, overflow = 0, zero = 1.
- Registered stage (all updates on the rising clk edge):
  - If reset: res_q = 0, flags_q = 4'b0000, valid_q = 0.
  - Else if en: res_q <= res, flags_q <= {carry, overflow, zero, negative}, valid_q <= 1.
  - Else: res_q and flags_q hold; valid_q <= 0.
- Latency: registered outputs reflect operands present at the capturing edge, one cycle later.
- Simultaneous reset and en: reset wins.
- Reset asserted mid-stream: registered outputs clear at the next edge; the combinational path is unaffected.
- No X propagation from the registered stage after the first reset edge.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - res_q saturates on signed overflow: to 0x7FF..F when op1 is non-negative, to 0x800..0 when op1 is negative.
  - flags_q still records the unsaturated overflow = 1.
  - zero and negative in flags_q describe the saturated value.
  - The combinational res is never saturated.
- Undefined: res_q always equals the captured modulo result; no saturation logic is present.

Test Plan:
- No clock toggling, sub=0, op1=0x00000001, op2=0x00000002, wait 10 ns -> res=0x00000003, carry=0, overflow=0, zero=0.
- sub=0, op1=0xFFFFFFFF, op2=0x00000001 -> res=0x00000000, carry=1, zero=1, overflow=0.
- sub=0, op1=0x7FFFFFFF, op2=0x00000001 -> res=0x80000000, overflow=1, negative=1, carry=0. With ADDER_SAT_EN, after an en edge: res_q=0x7FFFFFFF, flags_q[2]=1.
- sub=1, op1=5, op2=7 -> res=0xFFFFFFFE, carry=0, negative=1. sub=1, op1=7, op2=7 -> res=0, carry=1, zero=1.
- Registered stage:
  - Hold reset for 2 edges -> res_q=0, flags_q=0, valid_q=0.
  - en=1 with 3+4 -> next edge res_q=7, valid_q=1.
  - en=0 -> res_q holds 7, valid_q=0.
- reset=1 and en=1 on the same edge with nonzero operands -> res_q=0, valid_q=0; res still shows the live sum.
